// File: rtl/twofish_mds_mul.sv
// twofish_mds_mul
//   Iterative Twofish MDS stage: z = MDS * y over GF(2^8), modulus POLY.
//   Accumulates LANES matrix columns per cycle, so a result takes 4/LANES
//   cycles after acceptance. Constant multiplies are built from xtime chains.
//
//   state | meaning
//   IDLE  | waiting for in_y, in_ready = 1
//   BUSY  | accumulating columns col..col+LANES-1 into acc
//   DONE  | out_z valid, held until out_ready; may accept the next y directly
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_y valid
//   in_ready   block can accept in_y this cycle
//   in_y       y0 = [7:0], y1 = [15:8], y2 = [23:16], y3 = [31:24]
//   out_valid  out_z holds a completed result
//   out_ready  consumer takes out_z this cycle
//   out_z      z0 = [7:0] .. z3 = [31:24]
module twofish_mds_mul #(
    parameter int         LANES = 1,
    parameter logic [8:0] POLY  = 9'h169
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] y_q, y_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  col_q, col_d;
    logic [31:0] out_z_q, out_z_d;

    logic [31:0] term;
    logic [1:0]  col_last;
    logic        accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY[7:0] : 8'h00);
    endfunction

    // 0x5B = x^6 + x^4 + x^3 + x + 1
    function automatic logic [7:0] mul_5b(input logic [7:0] b);
        logic [7:0] b2, b4, b8, b16, b32, b64;
        b2  = xtime(b);
        b4  = xtime(b2);
        b8  = xtime(b4);
        b16 = xtime(b8);
        b32 = xtime(b16);
        b64 = xtime(b32);
        return b64 ^ b16 ^ b8 ^ b2 ^ b;
    endfunction

    // 0xEF = x^7 + x^6 + x^5 + x^3 + x^2 + x + 1
    function automatic logic [7:0] mul_ef(input logic [7:0] b);
        logic [7:0] b2, b4, b8, b16, b32, b64, b128;
        b2   = xtime(b);
        b4   = xtime(b2);
        b8   = xtime(b4);
        b16  = xtime(b8);
        b32  = xtime(b16);
        b64  = xtime(b32);
        b128 = xtime(b64);
        return b128 ^ b64 ^ b32 ^ b8 ^ b4 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] y_byte(input logic [31:0] y, input logic [1:0] idx);
        logic [7:0] r;
        case (idx)
            2'd0:    r = y[7:0];
            2'd1:    r = y[15:8];
            2'd2:    r = y[23:16];
            default: r = y[31:24];
        endcase
        return r;
    endfunction

    // One MDS column times its y byte, packed as {z3, z2, z1, z0}.
    function automatic logic [31:0] col_term(input logic [1:0] col, input logic [7:0] b);
        logic [7:0]  m5, me;
        logic [31:0] r;
        m5 = mul_5b(b);
        me = mul_ef(b);
        case (col)
            2'd0:    r = {me, me, m5, b};
            2'd1:    r = {b, m5, me, me};
            2'd2:    r = {me, b, me, m5};
            default: r = {m5, me, b, m5};
        endcase
        return r;
    endfunction

    always_comb begin
        term = '0;
        for (int l = 0; l < LANES; l++) begin
            term = term ^ col_term(col_q + 2'(l), y_byte(y_q, col_q + 2'(l)));
        end
    end

    assign col_last = col_q + 2'(LANES - 1);
    assign accept   = in_valid & in_ready;
    assign out_z    = out_z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            acc_q   <= '0;
            col_q   <= '0;
            out_z_q <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
            out_z_q <= out_z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        acc_d   = acc_q;
        col_d   = col_q;
        out_z_d = out_z_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d     = in_y;
                    acc_d   = '0;
                    col_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q ^ term;
                col_d = col_q + 2'(LANES);
                if (col_last == 2'd3) begin
                    out_z_d = acc_q ^ term;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    // Hand-off and new acceptance in the same cycle skip IDLE.
                    if (in_valid) begin
                        y_d     = in_y;
                        acc_d   = '0;
                        col_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_twofish_mds_mul.sv
// Bench for twofish_mds_mul: three instances, LANES = 1, 2, 4 (index k, LANES = 1 << k).
module tb_twofish_mds_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] in_y      [3];
    logic [31:0] out_z     [3];

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        twofish_mds_mul #(.LANES(1 << g), .POLY(9'h169)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_y      (in_y[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_z     (out_z[g])
        );
    end

    logic [7:0] mds_m [4][4] = '{
        '{8'h01, 8'hEF, 8'h5B, 8'h5B},
        '{8'h5B, 8'hEF, 8'hEF, 8'h01},
        '{8'hEF, 8'h5B, 8'h01, 8'hEF},
        '{8'hEF, 8'h01, 8'hEF, 8'h5B}
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        p  = 8'h00;
        aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = {aa[7:0], 1'b0};
            if (aa[8]) aa = aa ^ 9'h169;
        end
        return p;
    endfunction

    function automatic logic [31:0] mds_ref(input logic [31:0] y);
        logic [31:0] z;
        z = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                z[8*i +: 8] = z[8*i +: 8] ^ gf_mul(mds_m[i][j], y[8*j +: 8]);
        return z;
    endfunction

    // Drives one transaction on instance k; returns result, latency and ok=0 on timeout.
    task automatic run_txn(input int k, input logic [31:0] y,
                           output logic [31:0] z, output int lat, output bit ok);
        ok  = 1'b0;
        z   = '0;
        lat = -1;
        @(negedge clk);
        in_valid[k]  = 1'b1;
        in_y[k]      = y;
        out_ready[k] = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (in_ready[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin in_valid[k] = 1'b0; return; end
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_y[k]     = $urandom;
        lat         = 0;
        ok          = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (out_valid[k]) begin ok = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        if (!ok) return;
        z = out_z[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_y[k]      = 32'hDEADBEEF;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_z[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_state k=%0d in_ready=%b out_valid=%b out_z=%h required 1/0/00000000",
                         k, in_ready[k], out_valid[k], out_z[k]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle k=%0d in_ready=%b out_valid=%b required 1/0",
                         k, in_ready[k], out_valid[k]);
            end
        end
    endtask

    task automatic test_columns();
        logic [31:0] vec [6] = '{32'h00000001, 32'h00000100, 32'h00010000,
                                 32'h01000000, 32'h02000000, 32'h01010101};
        logic [31:0] exp [6] = '{32'hEFEF5B01, 32'h015BEFEF, 32'hEF01EF5B,
                                 32'h5BEF015B, 32'hB6B702B6, 32'h5A5A5AEE};
        logic [31:0] z, want;
        int lat;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 6; v++) begin
                sb.push_back(exp[v]);
                run_txn(k, vec[v], z, lat, ok);
                want = sb.pop_front();
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL columns_timeout k=%0d y=%h", k, vec[v]);
                end else if (z !== want) begin
                    failures++;
                    $display("FAIL columns_value k=%0d y=%h got=%h required=%h", k, vec[v], z, want);
                end
                checks++;
                if (lat != (4 >> k)) begin
                    failures++;
                    $display("FAIL columns_latency k=%0d y=%h got=%0d required=%0d", k, vec[v], lat, 4 >> k);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] want;
        int lat;
        bit ok;
        sb.push_back(32'h5A5A5AEE);
        sb.push_back(32'hB6B702B6);
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_y[0]      = 32'h01010101;
        out_ready[0] = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept in_ready=%b required 1", in_ready[0]);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (out_valid[0]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_first_result timeout out_valid=%b required 1", out_valid[0]);
        end
        in_valid[0] = 1'b1;
        in_y[0]     = 32'h02000000;
        want = sb.pop_front();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid[0] !== 1'b1 || out_z[0] !== want || in_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d out_valid=%b out_z=%h in_ready=%b required 1/%h/0",
                         n, out_valid[0], out_z[0], in_ready[0], want);
            end
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_release in_ready=%b required 1", in_ready[0]);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        in_y[0]      = $urandom;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_bubble out_valid=%b in_ready=%b required 0/0 (BUSY)",
                     out_valid[0], in_ready[0]);
        end
        lat = 0;
        ok  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid[0]) begin ok = 1'b1; break; end
            @(negedge clk);
            #1;
            lat++;
        end
        want = sb.pop_front();
        checks++;
        if (!ok || out_z[0] !== want || lat != 4) begin
            failures++;
            $display("FAIL bp_second_result ok=%0d out_z=%h lat=%0d required %h lat=4",
                     ok, out_z[0], lat, want);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_abort_reset();
        logic [31:0] z, want;
        int lat;
        bit ok;
        bit seen;
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_y[0]      = 32'hFFFFFFFF;
        out_ready[0] = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_accept in_ready=%b required 1", in_ready[0]);
        end
        @(negedge clk);          // col = 0
        in_valid[0] = 1'b0;
        @(negedge clk);          // col = 1
        @(negedge clk);          // col = 2
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_z[0] !== 32'h0) begin
            failures++;
            $display("FAIL abort_async out_valid=%b in_ready=%b out_z=%h required 0/1/00000000",
                     out_valid[0], in_ready[0], out_z[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_output out_valid seen=1 required 0");
        end
        sb.push_back(32'h015BEFEF);
        run_txn(0, 32'h00000100, z, lat, ok);
        want = sb.pop_front();
        checks++;
        if (!ok || z !== want || lat != 4) begin
            failures++;
            $display("FAIL abort_next ok=%0d got=%h lat=%0d required %h lat=4", ok, z, lat, want);
        end
    endtask

    task automatic rand_lane(input int k, input int nvec);
        logic [31:0] q[$];
        int  sent = 0;
        int  recv = 0;
        int  lat  = 0;
        int  cyc  = 0;
        bit  pending = 1'b0;
        bit  taken   = 1'b0;
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        while (recv < nvec && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            lat++;
            if (taken) begin in_valid[k] = 1'b0; taken = 1'b0; end
            if (!in_valid[k] && sent < nvec && $urandom_range(0, 3) != 0) begin
                in_valid[k] = 1'b1;
                in_y[k]     = $urandom;
            end
            out_ready[k] = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid[k]) begin
                if (pending) begin
                    pending = 1'b0;
                    checks++;
                    if (lat != (4 >> k)) begin
                        failures++;
                        $display("FAIL rand_latency k=%0d got=%0d required=%0d", k, lat, 4 >> k);
                    end
                end
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected k=%0d out_z=%h required no output", k, out_z[k]);
                end else if (out_z[k] !== q[0]) begin
                    failures++;
                    $display("FAIL rand_value k=%0d got=%h required=%h", k, out_z[k], q[0]);
                end
                if (out_ready[k] && q.size() > 0) begin
                    void'(q.pop_front());
                    recv++;
                end
            end
            if (in_valid[k] && in_ready[k]) begin
                q.push_back(mds_ref(in_y[k]));
                sent++;
                pending = 1'b1;
                lat     = -1;
                taken   = 1'b1;
            end
        end
        @(negedge clk);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        checks++;
        if (recv != nvec) begin
            failures++;
            $display("FAIL rand_timeout k=%0d received=%0d required=%0d", k, recv, nvec);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            automatic int kk = k;
            fork
                rand_lane(kk, 2000);
            join_none
        end
        wait fork;
    endtask

    initial begin
        test_reset();
        test_columns();
        test_back_pressure();
        test_abort_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
